adsr_pulse_overlay: RTL
=======================

ADSR_PULSE_OVERLAY -- requirements
Module: adsr_pulse_overlay

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of colour channels per pixel beat.
REQ-002 SHALL have parameter BITS, default 8, width of each channel sample.
REQ-003 SHALL have parameters IMAGE_WIDTH, default 640, and IMAGE_HEIGHT, default 480, active frame size.
REQ-004 SHALL have parameter TICK_DIV, default 200000, clock cycles per envelope tick (4 ms at 50 MHz).
REQ-005 SHALL have parameters ATTACK_STEP 16, DECAY_STEP 4, SUSTAIN_LEVEL 160, SUSTAIN_TICKS 40, RELEASE_STEP 2, envelope step sizes and levels, all in 8-bit gain units or ticks.
REQ-006 SHALL have parameters MAX_BPM, default 200, and STEP_SIZE, default (256*256)/MAX_BPM, BPM gain scale.
REQ-007 SHALL have ports: clk in 1 clock; reset in 1, synchronous active-high reset.
REQ-008 SHALL have ports: pix_in in CHANNELS*BITS; in_valid in 1; in_sop in 1, first pixel of frame; in_ready out 1.
REQ-009 SHALL have ports: pix_out out CHANNELS*BITS; out_valid out 1; out_sop out 1; out_ready in 1.
REQ-010 SHALL have ports: filter_enable in 1; beat_pulse in 1, one-cycle retrigger; BPM_estimate in $clog2(MAX_BPM+1); pulse_amplitude in BITS.
REQ-011 SHALL have debug ports: env_gain out 8; frame_gain out 8; adsr_state out 3.

Function
REQ-012 Pipeline SHALL be 2 register stages; advance enable en = out_ready OR NOT out_valid; in_ready = en; pixel accepted when in_valid AND in_ready.
REQ-013 Latency SHALL be exactly 2 enabled cycles from accepted pixel to out_valid; pix_out/out_sop SHALL hold stable while out_valid AND NOT out_ready.
REQ-014 Coordinates x,y SHALL count accepted pixels; x wraps at IMAGE_WIDTH-1 incrementing y; y wraps at IMAGE_HEIGHT-1 to 0; accepted in_sop forces that pixel to (0,0).
REQ-015 Stage 1 SHALL compute dx=x-IMAGE_WIDTH/2, dy=y-IMAGE_HEIGHT/2 signed, dist_sq=dx*dx+dy*dy (32-bit unsigned), r=pulse_amplitude>>1, r_sq=r*r.
REQ-016 Zone gain SHALL be: frame_gain if dist_sq < r_sq>>2; frame_gain>>1 if dist_sq < r_sq; else 0; r=0 gives 0 everywhere.
REQ-017 Stage 2 SHALL add zone gain to each channel independently with saturation at 2^BITS-1.
REQ-018 filter_enable=0 SHALL pass pix_in unchanged with same latency and handshake; envelope keeps running.
REQ-019 bpm_gain SHALL be min(255, (STEP_SIZE*BPM_estimate)>>8); frame_gain SHALL be (env_gain*bpm_gain)>>8, latched only on an accepted in_sop pixel (no mid-frame tearing).
REQ-020 Tick SHALL be one-cycle pulse every TICK_DIV cycles, free-running, independent of pixel flow.
REQ-021 Envelope FSM states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; env_gain and state change only on tick, except retrigger.
REQ-022 ATTACK: env += ATTACK_STEP saturating at 255; reaching 255 -> DECAY.
REQ-023 DECAY: env -= DECAY_STEP, clamped to SUSTAIN_LEVEL; reaching SUSTAIN_LEVEL -> SUSTAIN, sustain counter cleared.
REQ-024 SUSTAIN: hold env; after SUSTAIN_TICKS ticks -> RELEASE.
REQ-025 RELEASE: env -= RELEASE_STEP clamped at 0; reaching 0 -> IDLE.
REQ-026 beat_pulse SHALL force ATTACK next cycle from any state, env retained (no jump to 0); beat_pulse on a tick cycle takes priority over tick transition.

Reset
REQ-027 Reset SHALL clear: both pipeline valids, pix_out, out_sop, x, y, tick counter, env_gain, frame_gain, sustain counter; state=IDLE; in_ready=1 the cycle after reset.
REQ-028 Reset mid-frame SHALL discard in-flight pixels; next accepted pixel is (0,0).

Structure
REQ-029 Package adsr_pkg SHALL hold the adsr_state_t enum and default envelope constants.
REQ-030 Sub-module adsr_envelope SHALL contain tick divider, FSM and env_gain; pixel pipeline in top.

Verification (TICK_DIV=4, 8x8 frame, ATTACK_STEP=64, DECAY_STEP=32, SUSTAIN_LEVEL=160, SUSTAIN_TICKS=2, RELEASE_STEP=80)
REQ-031 beat_pulse from IDLE -> env 64,128,192,255 on ticks 1-4, then 223,191,160, SUSTAIN 2 ticks, 80, 0, IDLE.
REQ-032 beat_pulse during RELEASE at env=80 -> ATTACK, env 144 next tick.
REQ-033 frame_gain=200, pulse_amplitude=8, pixel (4,4) value 100 per channel -> 255 saturated; (4,6) -> 200; (0,0) -> 100.
REQ-034 out_ready low 5 cycles with streaming input -> in_ready low, pix_out stable, no pixel lost or duplicated over 64 pixels.
REQ-035 filter_enable=0, BPM_estimate=200 -> pix_out equals pix_in delayed 2 cycles.
REQ-036 reset asserted at pixel 20 -> out_valid 0 next cycle, env_gain 0, next in_sop-less pixel counted at (0,0).

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared envelope state encoding and default envelope constants for the
// ADSR pulse overlay.
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    localparam int unsigned DEF_TICK_DIV      = 200000;
    localparam int unsigned DEF_ATTACK_STEP   = 16;
    localparam int unsigned DEF_DECAY_STEP    = 4;
    localparam int unsigned DEF_SUSTAIN_LEVEL = 160;
    localparam int unsigned DEF_SUSTAIN_TICKS = 40;
    localparam int unsigned DEF_RELEASE_STEP  = 2;

    function automatic logic [7:0] sat_u8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/adsr_envelope.sv
// Free-running envelope tick divider plus the ADSR state machine that
// produces the 8-bit envelope gain; beat_pulse retriggers the attack.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
    parameter int unsigned ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter int unsigned DECAY_STEP    = DEF_DECAY_STEP,
    parameter int unsigned SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter int unsigned SUSTAIN_TICKS = DEF_SUSTAIN_TICKS,
    parameter int unsigned RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        beat_pulse,
    output logic [7:0]  env_gain,
    output adsr_state_t state
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [9:0]  A_STEP    = 10'(ATTACK_STEP);
    localparam logic [9:0]  D_STEP    = 10'(DECAY_STEP);
    localparam logic [9:0]  R_STEP    = 10'(RELEASE_STEP);
    localparam logic [9:0]  SUS_LVL   = 10'(SUSTAIN_LEVEL);
    localparam logic [15:0] SUS_TICKS = 16'(SUSTAIN_TICKS);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    adsr_state_t   state_q, state_d;
    logic [7:0]    env_q, env_d;
    logic [15:0]   sus_q, sus_d;
    logic [9:0]    env_ext;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign env_ext    = {2'b00, env_q};

    // Retrigger wins over a coincident tick and keeps the current level.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        sus_d   = sus_q;
        if (beat_pulse) begin
            state_d = ST_ATTACK;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: ;
                ST_ATTACK: begin
                    if (env_ext + A_STEP >= 10'd255) begin
                        env_d   = 8'hFF;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = 8'(env_ext + A_STEP);
                    end
                end
                ST_DECAY: begin
                    if (env_ext <= SUS_LVL + D_STEP) begin
                        env_d   = 8'(SUS_LVL);
                        state_d = ST_SUSTAIN;
                        sus_d   = '0;
                    end else begin
                        env_d = 8'(env_ext - D_STEP);
                    end
                end
                ST_SUSTAIN: begin
                    sus_d = sus_q + 16'd1;
                    if (sus_q + 16'd1 >= SUS_TICKS) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (env_ext <= R_STEP) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = 8'(env_ext - R_STEP);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            env_q      <= '0;
            sus_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            env_q      <= env_d;
            sus_q      <= sus_d;
        end
    end

    assign env_gain = env_q;
    assign state    = state_q;

endmodule

// File: rtl/adsr_pulse_overlay.sv
// Two-stage pixel pipeline that brightens a centred disc by an envelope-
// and BPM-scaled gain; the gain is latched per frame on start-of-packet.
module adsr_pulse_overlay
    import adsr_pkg::*;
#(
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned BITS          = 8,
    parameter int unsigned IMAGE_WIDTH   = 640,
    parameter int unsigned IMAGE_HEIGHT  = 480,
    parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
    parameter int unsigned ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter int unsigned DECAY_STEP    = DEF_DECAY_STEP,
    parameter int unsigned SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter int unsigned SUSTAIN_TICKS = DEF_SUSTAIN_TICKS,
    parameter int unsigned RELEASE_STEP  = DEF_RELEASE_STEP,
    parameter int unsigned MAX_BPM       = 200,
    parameter int unsigned STEP_SIZE     = (256 * 256) / MAX_BPM
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*BITS-1:0]     pix_in,
    input  logic                         in_valid,
    input  logic                         in_sop,
    output logic                         in_ready,
    output logic [CHANNELS*BITS-1:0]     pix_out,
    output logic                         out_valid,
    output logic                         out_sop,
    input  logic                         out_ready,
    input  logic                         filter_enable,
    input  logic                         beat_pulse,
    input  logic [$clog2(MAX_BPM+1)-1:0] BPM_estimate,
    input  logic [BITS-1:0]              pulse_amplitude,
    output logic [7:0]                   env_gain,
    output logic [7:0]                   frame_gain,
    output logic [2:0]                   adsr_state
);

    localparam int unsigned PW = CHANNELS * BITS;
    localparam int unsigned XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned SW = ((BITS > 8) ? BITS : 8) + 1;

    adsr_state_t env_state;

    adsr_envelope #(
        .TICK_DIV      (TICK_DIV),
        .ATTACK_STEP   (ATTACK_STEP),
        .DECAY_STEP    (DECAY_STEP),
        .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
        .SUSTAIN_TICKS (SUSTAIN_TICKS),
        .RELEASE_STEP  (RELEASE_STEP)
    ) u_env (
        .clk        (clk),
        .reset      (reset),
        .beat_pulse (beat_pulse),
        .env_gain   (env_gain),
        .state      (env_state)
    );

    logic          en, accept;
    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    logic          v1_q, v1_d, sop1_q, sop1_d, filt1_q, filt1_d;
    logic [PW-1:0] pix1_q, pix1_d;
    logic [31:0]   dist1_q, dist1_d, rsq1_q, rsq1_d;
    logic          v2_q, v2_d, sop2_q, sop2_d;
    logic [PW-1:0] pix2_q, pix2_d, sat_pix;
    logic [7:0]    frame_gain_q, frame_gain_d, bpm_gain, zone_gain;
    logic [15:0]   fg_prod;
    logic signed [31:0] dx, dy;
    logic [31:0]   dist_sq, r_sq, bpm_prod;
    logic [BITS-1:0] r;
    logic [SW-1:0] ch_sum;

    assign en       = out_ready | ~v2_q;
    assign accept   = in_valid & en;
    assign px       = in_sop ? '0 : x_q;
    assign py       = in_sop ? '0 : y_q;
    assign dx       = 32'(px) - 32'(IMAGE_WIDTH / 2);
    assign dy       = 32'(py) - 32'(IMAGE_HEIGHT / 2);
    assign dist_sq  = dx * dx + dy * dy;
    assign r        = pulse_amplitude >> 1;
    assign r_sq     = 32'(r) * 32'(r);
    assign bpm_prod = 32'(STEP_SIZE) * 32'(BPM_estimate);
    assign bpm_gain = sat_u8(bpm_prod >> 8);
    assign fg_prod  = {8'h00, env_gain} * {8'h00, bpm_gain};

    always_comb begin
        if (dist1_q < (rsq1_q >> 2))  zone_gain = frame_gain_q;
        else if (dist1_q < rsq1_q)    zone_gain = {1'b0, frame_gain_q[7:1]};
        else                          zone_gain = '0;
    end

    always_comb begin
        sat_pix = '0;
        ch_sum  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            ch_sum = SW'(pix1_q[c*BITS +: BITS]) + SW'(zone_gain);
            sat_pix[c*BITS +: BITS] = (|ch_sum[SW-1:BITS]) ? '1 : ch_sum[BITS-1:0];
        end
    end

    // Both stages move together on en so a stalled output holds every stage.
    always_comb begin
        v1_d = v1_q;  sop1_d = sop1_q;  filt1_d = filt1_q;  pix1_d = pix1_q;
        dist1_d = dist1_q;  rsq1_d = rsq1_q;
        v2_d = v2_q;  sop2_d = sop2_q;  pix2_d = pix2_q;
        x_d = x_q;  y_d = y_q;  frame_gain_d = frame_gain_q;
        if (en) begin
            v1_d    = accept;
            sop1_d  = accept & in_sop;
            filt1_d = filter_enable;
            pix1_d  = pix_in;
            dist1_d = dist_sq;
            rsq1_d  = r_sq;
            v2_d    = v1_q;
            sop2_d  = sop1_q;
            pix2_d  = filt1_q ? sat_pix : pix1_q;
        end
        if (accept) begin
            if (px == XW'(IMAGE_WIDTH - 1)) begin
                x_d = '0;
                y_d = (py == YW'(IMAGE_HEIGHT - 1)) ? '0 : py + 1'b1;
            end else begin
                x_d = px + 1'b1;
                y_d = py;
            end
            if (in_sop) frame_gain_d = fg_prod[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;  sop1_q <= 1'b0;  filt1_q <= 1'b0;  pix1_q <= '0;
            dist1_q <= '0;  rsq1_q <= '0;
            v2_q <= 1'b0;  sop2_q <= 1'b0;  pix2_q <= '0;
            x_q <= '0;  y_q <= '0;  frame_gain_q <= '0;
        end else begin
            v1_q <= v1_d;  sop1_q <= sop1_d;  filt1_q <= filt1_d;  pix1_q <= pix1_d;
            dist1_q <= dist1_d;  rsq1_q <= rsq1_d;
            v2_q <= v2_d;  sop2_q <= sop2_d;  pix2_q <= pix2_d;
            x_q <= x_d;  y_q <= y_d;  frame_gain_q <= frame_gain_d;
        end
    end

    assign in_ready   = en;
    assign pix_out    = pix2_q;
    assign out_valid  = v2_q;
    assign out_sop    = sop2_q;
    assign frame_gain = frame_gain_q;
    assign adsr_state = env_state;

endmodule
